// File: rtl/msg_streamer_pkg.sv
`default_nettype none
// ============================================================================
// msg_streamer_pkg : state encodings and default terminator for msg_streamer
// Revision: 1.0
// ============================================================================
package msg_streamer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_CHECK = 3'd2,
    ST_SEND  = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  // Shared with the SoC top so the string tables and streamer agree.
  localparam logic [7:0] C_DEFAULT_TERMINATOR = 8'h00;

endpackage
`default_nettype wire

// File: rtl/msg_streamer.sv
`default_nettype none
// ============================================================================
// msg_streamer : streams a terminator-delimited string from BRAM to UART TX
// Revision: 1.0
// ============================================================================
module msg_streamer
  import msg_streamer_pkg::*;
#(
  parameter int         AddrWidth  = 19,
  parameter int         MaxLen     = 256,
  parameter logic [7:0] Terminator = C_DEFAULT_TERMINATOR
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [AddrWidth-1:0] BASE,
  input  logic                 ABORT,
  output logic [AddrWidth-1:0] MADDR,
  output logic                 MRD,
  input  logic [7:0]           MDIN,
  output logic [7:0]           TX_DATA,
  output logic                 TX_VALID,
  input  logic                 TX_RDY,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [15:0]          COUNT
);

  state_t                 state_q, state_d;
  logic [AddrWidth-1:0]   maddr_q, maddr_d;
  logic                   mrd_q, mrd_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   tx_valid_q, tx_valid_d;
  logic [15:0]            count_q, count_d;
  logic                   abort_pend_q, abort_pend_d;
  logic [15:0]            count_inc;

  assign count_inc = count_q + 16'd1;

  always_comb begin
    state_d      = state_q;
    maddr_d      = maddr_q;
    mrd_d        = mrd_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    count_d      = count_q;
    // An abort is only latched here; it is acted on at CHECK or at a transfer.
    abort_pend_d = abort_pend_q | (ABORT && (state_q != ST_IDLE));

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d      = ST_READ;
          maddr_d      = BASE;
          count_d      = 16'd0;
          mrd_d        = 1'b1;
          abort_pend_d = 1'b0;
        end
      end
      ST_READ: begin
        mrd_d   = 1'b0;
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if ((MDIN == Terminator) || abort_pend_q) begin
          state_d = ST_FIN;
        end else begin
          tx_data_d  = MDIN;
          tx_valid_d = 1'b1;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_valid_q && TX_RDY) begin
          tx_valid_d = 1'b0;
          count_d    = count_inc;
          maddr_d    = maddr_q + 1'b1;
          if ((count_inc == 16'(MaxLen)) || abort_pend_q) begin
            state_d = ST_FIN;
          end else begin
            mrd_d   = 1'b1;
            state_d = ST_READ;
          end
        end
      end
      ST_FIN: begin
        abort_pend_d = 1'b0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      maddr_q      <= '0;
      mrd_q        <= 1'b0;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      count_q      <= 16'd0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      maddr_q      <= maddr_d;
      mrd_q        <= mrd_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      count_q      <= count_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  assign MADDR    = maddr_q;
  assign MRD      = mrd_q;
  assign TX_DATA  = tx_data_q;
  assign TX_VALID = tx_valid_q;
  assign COUNT    = count_q;
  assign BUSY     = (state_q != ST_IDLE);
  assign DONE     = (state_q == ST_FIN);

endmodule
`default_nettype wire

// File: tb/tb_msg_streamer.sv
`default_nettype none
// ============================================================================
// tb_msg_streamer : directed self-checking bench for msg_streamer
// Revision: 1.0
// ============================================================================
module tb_msg_streamer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // Main instance (MaxLen = 256)
  logic        start = 1'b0, abort = 1'b0, tx_rdy = 1'b0;
  logic [18:0] base = '0;
  logic [18:0] maddr;
  logic        mrd, tx_valid, busy, done;
  logic [7:0]  mdin = 8'h00, tx_data;
  logic [15:0] count;

  // Length-bounded instance (MaxLen = 4)
  logic        start4 = 1'b0, tx_rdy4 = 1'b0;
  logic [18:0] base4 = '0;
  logic [18:0] maddr4;
  logic        mrd4, tx_valid4, busy4, done4;
  logic [7:0]  mdin4 = 8'h00, tx_data4;
  logic [15:0] count4;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem [logic [18:0]];
  logic [7:0] log_q[$];
  logic [7:0] log4_q[$];
  int mrd_cnt = 0, done_cnt = 0, mrd4_cnt = 0;

  always #5 clk = ~clk;

  msg_streamer #(.AddrWidth(19), .MaxLen(256), .Terminator(8'h00)) dut (
    .CLK(clk), .RST(rst_n), .START(start), .BASE(base), .ABORT(abort),
    .MADDR(maddr), .MRD(mrd), .MDIN(mdin), .TX_DATA(tx_data),
    .TX_VALID(tx_valid), .TX_RDY(tx_rdy), .BUSY(busy), .DONE(done),
    .COUNT(count)
  );

  msg_streamer #(.AddrWidth(19), .MaxLen(4), .Terminator(8'h00)) dut4 (
    .CLK(clk), .RST(rst_n), .START(start4), .BASE(base4), .ABORT(1'b0),
    .MADDR(maddr4), .MRD(mrd4), .MDIN(mdin4), .TX_DATA(tx_data4),
    .TX_VALID(tx_valid4), .TX_RDY(tx_rdy4), .BUSY(busy4), .DONE(done4),
    .COUNT(count4)
  );

  function automatic logic [7:0] rd(input logic [18:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic logic [63:0] packq(input logic [7:0] q[$]);
    logic [63:0] r = '0;
    foreach (q[i]) r = {r[55:0], q[i]};
    return r;
  endfunction

  // Synchronous-read memory models and transfer monitors
  always @(posedge clk) begin
    if (mrd)  mdin  <= rd(maddr);
    if (mrd4) mdin4 <= rd(maddr4);
    if (rst_n) begin
      if (tx_valid && tx_rdy)   log_q.push_back(tx_data);
      if (tx_valid4 && tx_rdy4) log4_q.push_back(tx_data4);
      if (mrd)  mrd_cnt++;
      if (mrd4) mrd4_cnt++;
      if (done) done_cnt++;
    end
  end

  task automatic clear_logs();
    log_q.delete(); log4_q.delete();
    mrd_cnt = 0; done_cnt = 0; mrd4_cnt = 0;
  endtask

  task automatic load(input logic [18:0] a, input string s);
    for (int i = 0; i < s.len(); i++) mem[a + 19'(i)] = s[i];
    mem[a + 19'(s.len())] = 8'h00;
  endtask

  task automatic do_start(input logic [18:0] b);
    @(negedge clk); base = b; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_valid) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({maddr, mrd, tx_data, tx_valid, busy, done, count} !== '0) begin
      n_err++;
      $display("FAIL reset_values: maddr=%h mrd=%b data=%h valid=%b busy=%b done=%b count=%0d, want all 0",
               maddr, mrd, tx_data, tx_valid, busy, done, count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bit ok;
    mem.delete(); load(19'h10, "Hi"); clear_logs();
    tx_rdy = 1'b1;
    do_start(19'h10);
    wait_done(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL basic_done: done=0 after timeout, want 1"); end
    n_cmp++;
    if (count !== 16'd2) begin n_err++; $display("FAIL basic_count: got %0d want 2", count); end
    n_cmp++;
    if (maddr !== 19'h12) begin n_err++; $display("FAIL basic_maddr: got %h want 12", maddr); end
    @(negedge clk);
    n_cmp++;
    if (log_q.size() != 2 || packq(log_q) !== 64'h4869) begin
      n_err++; $display("FAIL basic_bytes: got %h (n=%0d) want 4869", packq(log_q), log_q.size());
    end
    n_cmp++;
    if (busy !== 1'b0 || done_cnt != 1) begin
      n_err++; $display("FAIL basic_end: busy=%b dones=%0d want busy=0 dones=1", busy, done_cnt);
    end
  endtask

  task automatic test_backpressure();
    bit ok; int bad = 0; int mrd_snap;
    clear_logs(); tx_rdy = 1'b0;
    do_start(19'h10);
    wait_valid(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL bp_valid: tx_valid=0 after timeout, want 1"); end
    mrd_snap = mrd_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== 8'h48) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL bp_hold: %0d unstable cycles, want 0", bad); end
    n_cmp++;
    if (mrd_cnt != mrd_snap) begin n_err++; $display("FAIL bp_mrd: got %0d reads want %0d", mrd_cnt, mrd_snap); end
    tx_rdy = 1'b1;
    wait_done(ok);
    @(negedge clk);
    n_cmp++;
    if (!ok || packq(log_q) !== 64'h4869 || mrd_cnt != 3) begin
      n_err++; $display("FAIL bp_result: bytes=%h reads=%0d done=%b want 4869 reads=3 done=1",
                        packq(log_q), mrd_cnt, ok);
    end
  endtask

  task automatic test_length();
    bit ok = 0;
    mem.delete(); load(19'h20, "ABCDEFG"); clear_logs();
    tx_rdy4 = 1'b1;
    @(negedge clk); base4 = 19'h20; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (done4) ok = 1;
    end
    n_cmp++;
    if (!ok || count4 !== 16'd4) begin
      n_err++; $display("FAIL len_count: count=%0d done=%b want 4 done=1", count4, ok);
    end
    @(negedge clk);
    n_cmp++;
    if (packq(log4_q) !== 64'h41424344 || log4_q.size() != 4) begin
      n_err++; $display("FAIL len_bytes: got %h want 41424344", packq(log4_q));
    end
    n_cmp++;
    if (mrd4_cnt != 4 || busy4 !== 1'b0) begin
      n_err++; $display("FAIL len_reads: reads=%0d busy=%b want 4 and 0", mrd4_cnt, busy4);
    end
  endtask

  task automatic test_abort();
    bit ok;
    mem.delete(); load(19'h30, "ABCDEF"); clear_logs();
    tx_rdy = 1'b0;
    do_start(19'h30);
    wait_valid(ok);
    tx_rdy = 1'b1;
    @(negedge clk); tx_rdy = 1'b0;
    wait_valid(ok);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    repeat (2) @(negedge clk);
    tx_rdy = 1'b1;
    wait_done(ok);
    n_cmp++;
    if (!ok || count !== 16'd2) begin
      n_err++; $display("FAIL abort_count: count=%0d done=%b want 2 done=1", count, ok);
    end
    @(negedge clk);
    n_cmp++;
    if (packq(log_q) !== 64'h4142 || mrd_cnt != 2) begin
      n_err++; $display("FAIL abort_bytes: bytes=%h reads=%0d want 4142 reads=2", packq(log_q), mrd_cnt);
    end
  endtask

  task automatic test_empty();
    logic [1:0] seen;
    mem.delete(); clear_logs(); tx_rdy = 1'b1;
    do_start(19'h0);
    @(negedge clk); seen[1] = done;
    @(negedge clk); seen[0] = done;
    n_cmp++;
    if (seen !== 2'b01 || count !== 16'd0) begin
      n_err++; $display("FAIL empty_done: done seq=%b count=%0d want 01 and 0", seen, count);
    end
    @(negedge clk);
    n_cmp++;
    if (log_q.size() != 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL empty_tx: sent=%0d busy=%b want 0 and 0", log_q.size(), busy);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    mem.delete(); mem[19'h7FFFF] = 8'h58; mem[19'h0] = 8'h00; clear_logs();
    tx_rdy = 1'b1;
    do_start(19'h7FFFF);
    wait_done(ok);
    n_cmp++;
    if (!ok || count !== 16'd1 || maddr !== 19'h0) begin
      n_err++; $display("FAIL wrap: count=%0d maddr=%h done=%b want 1, 00000, 1", count, maddr, ok);
    end
    @(negedge clk);
    n_cmp++;
    if (packq(log_q) !== 64'h58 || mrd_cnt != 2) begin
      n_err++; $display("FAIL wrap_bytes: bytes=%h reads=%0d want 58 reads=2", packq(log_q), mrd_cnt);
    end
  endtask

  task automatic test_start_busy();
    bit ok;
    mem.delete(); load(19'h10, "Hi"); load(19'h30, "ABCDEF"); clear_logs();
    tx_rdy = 1'b0;
    do_start(19'h10);
    wait_valid(ok);
    do_start(19'h30);
    tx_rdy = 1'b1;
    wait_done(ok);
    n_cmp++;
    if (!ok || maddr !== 19'h12 || count !== 16'd2) begin
      n_err++; $display("FAIL busy_start: maddr=%h count=%0d done=%b want 12, 2, 1", maddr, count, ok);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (packq(log_q) !== 64'h4869 || busy !== 1'b0 || done_cnt != 1) begin
      n_err++; $display("FAIL busy_after: bytes=%h busy=%b dones=%0d want 4869, 0, 1",
                        packq(log_q), busy, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    mem.delete(); load(19'h10, "Hi"); load(19'h30, "ABCDEF");
    tx_rdy = 1'b0;
    do_start(19'h30);
    wait_valid(ok);
    clear_logs();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({tx_valid, busy, mrd, done} !== 4'b0000) begin
      n_err++; $display("FAIL reset_async: valid=%b busy=%b mrd=%b done=%b want 0000",
                        tx_valid, busy, mrd, done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tx_rdy = 1'b1;
    do_start(19'h10);
    wait_done(ok);
    @(negedge clk);
    n_cmp++;
    if (!ok || packq(log_q) !== 64'h4869 || count !== 16'd2 || done_cnt != 1) begin
      n_err++; $display("FAIL reset_restart: bytes=%h count=%0d dones=%0d want 4869, 2, 1",
                        packq(log_q), count, done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_length();
    test_abort();
    test_empty();
    test_wrap();
    test_start_busy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
